// File: rtl/effect_sequencer.sv
// Effect sequencer: passes each codec sample through the enabled effect slots in order,
// bypassing any slot that fails to answer within TIMEOUT cycles.
module effect_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_FX     = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        sample_in,
    input  logic                         sample_valid,
    input  logic [NUM_FX-1:0]            fx_enable,
    input  logic                         save_enable,
    input  logic [NUM_FX-1:0]            fx_done,
    input  logic [NUM_FX*DATA_WIDTH-1:0] fx_result,
    output logic [NUM_FX-1:0]            fx_cs,
    output logic [NUM_FX-1:0]            fx_my_turn,
    output logic [DATA_WIDTH-1:0]        fx_data,
    output logic                         fx_should_save,
    output logic [DATA_WIDTH-1:0]        sample_out,
    output logic                         sample_out_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic [NUM_FX-1:0]            fx_timeout
);

    localparam int IDX_W = $clog2(NUM_FX + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_FX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   cur_q, cur_d;
    logic [NUM_FX-1:0]       en_q, en_d;
    logic                    save_q, save_d;
    logic [NUM_FX-1:0]       turn_q, turn_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic [NUM_FX-1:0]       timeout_q, timeout_d;
    logic [NUM_FX-1:0]       done_prev_q;

    // One-hot of the current slot; all-zero once idx has walked past the last slot.
    logic [NUM_FX-1:0]       slot_sel_s;
    logic                    slot_en_s;
    logic                    done_edge_s;
    logic [DATA_WIDTH-1:0]   slot_result_s;

    assign slot_sel_s    = NUM_FX'(1) << idx_q;
    assign slot_en_s     = |(en_q & slot_sel_s);
    assign done_edge_s   = |(fx_done & ~done_prev_q & slot_sel_s);
    assign slot_result_s = DATA_WIDTH'(fx_result >> (DATA_WIDTH * idx_q));

    // Next-state and datapath decisions for the slot walk.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cur_d       = cur_q;
        en_d        = en_q;
        save_d      = save_q;
        turn_d      = turn_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q | (sample_valid & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    cur_d   = sample_in;
                    idx_d   = {IDX_W{1'b0}};
                    en_d    = fx_enable;
                    save_d  = save_enable;
                    state_d = SELECT;
                end else begin
                    state_d = IDLE;
                end
            end
            SELECT: begin
                if (idx_q == IDX_END) begin
                    out_d       = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (slot_en_s) begin
                    turn_d  = slot_sel_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = WAIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT: begin
                // A done edge beats a timeout landing in the same cycle.
                if (done_edge_s) begin
                    cur_d   = slot_result_s;
                    turn_d  = {NUM_FX{1'b0}};
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SELECT;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = timeout_q | slot_sel_s;
                    turn_d    = {NUM_FX{1'b0}};
                    idx_d     = idx_q + IDX_W'(1);
                    state_d   = SELECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= {IDX_W{1'b0}};
            cur_q       <= {DATA_WIDTH{1'b0}};
            en_q        <= {NUM_FX{1'b0}};
            save_q      <= 1'b0;
            turn_q      <= {NUM_FX{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_q       <= {DATA_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= {NUM_FX{1'b0}};
            done_prev_q <= {NUM_FX{1'b0}};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_q       <= cur_d;
            en_q        <= en_d;
            save_q      <= save_d;
            turn_q      <= turn_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            done_prev_q <= fx_done;
        end
    end

    assign fx_cs            = en_q;
    assign fx_my_turn       = turn_q;
    assign fx_data          = cur_q;
    assign fx_should_save   = save_q;
    assign sample_out       = out_q;
    assign sample_out_valid = out_valid_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;
    assign fx_timeout       = timeout_q;

endmodule

// File: tb/tb_effect_sequencer.sv
// Scoreboard bench for effect_sequencer: behavioural effect slots, a transaction-level
// reference model, and a monitor that checks outputs as they appear.
module tb_effect_sequencer;

    localparam int DW = 16;
    localparam int NF = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   sample_in;
    logic            sample_valid;
    logic [NF-1:0]   fx_enable;
    logic            save_enable;
    logic [NF-1:0]   fx_done;
    logic [NF*DW-1:0] fx_result;
    logic [NF-1:0]   fx_cs;
    logic [NF-1:0]   fx_my_turn;
    logic [DW-1:0]   fx_data;
    logic            fx_should_save;
    logic [DW-1:0]   sample_out;
    logic            sample_out_valid;
    logic            busy;
    logic            overrun;
    logic [NF-1:0]   fx_timeout;

    effect_sequencer #(.DATA_WIDTH(DW), .NUM_FX(NF), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .fx_enable(fx_enable), .save_enable(save_enable), .fx_done(fx_done),
        .fx_result(fx_result), .fx_cs(fx_cs), .fx_my_turn(fx_my_turn), .fx_data(fx_data),
        .fx_should_save(fx_should_save), .sample_out(sample_out),
        .sample_out_valid(sample_out_valid), .busy(busy), .overrun(overrun),
        .fx_timeout(fx_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] fx_fn(input int i, input logic [DW-1:0] x);
        case (i)
            0:       return x + 16'd1;
            1:       return x ^ 16'h5A5A;
            2:       return {x[DW-2:0], 1'b0};
            default: return ~x;
        endcase
    endfunction

    // Behavioural effect slots: result appears lat cycles after my_turn rises.
    int            lat[NF]     = '{default: 3};
    int            ref_lat[NF] = '{default: 3};
    int            ecnt[NF]    = '{default: 0};
    logic [DW-1:0] res[NF]     = '{default: 16'h0};
    logic [NF-1:0] done_int    = 4'b0;
    logic [NF-1:0] force_hi    = 4'b0;
    logic [NF-1:0] noise       = 4'b0;
    logic [NF-1:0] noise_en    = 4'b0;

    assign fx_done   = done_int | force_hi | noise;
    assign fx_result = {res[3], res[2], res[1], res[0]};

    always @(posedge clk) begin
        noise <= noise_en & 4'($urandom);
        for (int i = 0; i < NF; i++) begin
            if (fx_my_turn[i]) begin
                if (ecnt[i] + 1 == lat[i]) begin
                    done_int[i] <= 1'b1;
                    res[i]      <= fx_fn(i, fx_data);
                end
                ecnt[i] <= ecnt[i] + 1;
            end else begin
                ecnt[i]     <= 0;
                done_int[i] <= 1'b0;
                res[i]      <= 16'($urandom);
            end
        end
    end

    // Reference: enabled slot answering in L cycles costs L+2 cycles, a silent one TO+1, a disabled one 1.
    function automatic void ref_model(input logic [DW-1:0] x, input logic [NF-1:0] en,
                                      output logic [DW-1:0] y, output int s,
                                      output logic [NF-1:0] tm);
        y  = x;
        s  = 0;
        tm = 4'b0;
        for (int i = 0; i < NF; i++) begin
            if (!en[i]) begin
                s += 1;
            end else if (ref_lat[i] <= TO - 1) begin
                y = fx_fn(i, y);
                s += ref_lat[i] + 2;
            end else begin
                tm[i] = 1'b1;
                s += TO + 1;
            end
        end
    endfunction

    logic [DW-1:0] exp_v[$];
    int            exp_c[$];
    int            exp_turn[$];
    logic [NF-1:0] exp_tmask = 4'b0;
    logic          exp_ovr   = 1'b0;
    logic [NF-1:0] prev_turn = 4'b0;

    // Monitor: dispatch order and output samples are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        int            s;
        logic [DW-1:0] v;
        int            c;
        if (!rst) begin
            chk("turn_onehot", 64'($countones(fx_my_turn) <= 1), 64'(1));
            if (fx_my_turn != prev_turn && fx_my_turn != 4'b0) begin
                if (exp_turn.size() == 0) begin
                    chk("turn_unexpected", 64'(fx_my_turn), 64'(0));
                end else begin
                    s = exp_turn.pop_front();
                    chk("turn_order", 64'(fx_my_turn), 64'(4'b1 << s));
                end
            end
            if (sample_out_valid) begin
                if (exp_v.size() == 0) begin
                    chk("out_unexpected", 64'(sample_out_valid), 64'(0));
                end else begin
                    v = exp_v.pop_front();
                    c = exp_c.pop_front();
                    chk("sample_out", 64'(sample_out), 64'(v));
                    chk("out_latency", 64'(cyc), 64'(c));
                end
            end
        end
        prev_turn <= fx_my_turn;
    end

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
        ref_lat = lat;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (exp_v.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_in_time", 64'(exp_v.size()), 64'(0));
        chk("turns_drained", 64'(exp_turn.size()), 64'(0));
        @(negedge clk);
    endtask

    // ovr: 0 none, >0 extra pulse that many cycles later, -1 random inside busy window, -2 on return to idle.
    task automatic issue(input logic [DW-1:0] x, input logic [NF-1:0] en, input logic sv, input int ovr);
        logic [DW-1:0] y;
        int            s;
        int            k;
        logic [NF-1:0] tm;
        ref_model(x, en, y, s, tm);
        exp_v.push_back(y);
        exp_c.push_back(cyc + s + 2);
        for (int i = 0; i < NF; i++) if (en[i]) exp_turn.push_back(i);
        exp_tmask    = exp_tmask | tm;
        noise_en     = ~en;
        sample_in    = x;
        fx_enable    = en;
        save_enable  = sv;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'(1));
        chk("fx_cs_snapshot", 64'(fx_cs), 64'(en));
        chk("should_save_snapshot", 64'(fx_should_save), 64'(sv));
        chk("fx_data_cur", 64'(fx_data), 64'(x));
        fx_enable   = ~en;
        save_enable = ~sv;
        sample_in   = 16'($urandom);
        k = (ovr == -1) ? int'($urandom_range(s + 1, 1)) : ((ovr == -2) ? s + 1 : ovr);
        if (k > 0) begin
            repeat (k - 1) @(negedge clk);
            sample_valid = 1'b1;
            exp_ovr      = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        rst          = 1'b1;
        sample_in    = 16'h0;
        sample_valid = 1'b0;
        fx_enable    = 4'b0;
        save_enable  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({fx_cs, fx_my_turn, fx_data, fx_should_save, sample_out,
                                   sample_out_valid, busy, overrun, fx_timeout}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_not_busy", 64'(busy), 64'(0));

        // All slots bypassed: fixed 5-cycle latency, no dispatch.
        set_lat(3, 3, 3, 3);
        issue(16'h1234, 4'b0000, 1'b0, 0);
        // Slots 0 and 2: (10+1)*2.
        set_lat(3, 5, 2, 4);
        issue(16'd10, 4'b0101, 1'b1, 0);
        chk("no_overrun_yet", 64'(overrun), 64'(0));
        chk("no_timeout_yet", 64'(fx_timeout), 64'(0));
        // Silent slot 1 is bypassed and flagged.
        set_lat(3, 1000, 3, 3);
        issue(16'h00AA, 4'b0010, 1'b0, 0);
        chk("timeout_slot1", 64'(fx_timeout), 64'(4'b0010));
        // Done edge on the last allowed cycle still wins.
        set_lat(TO - 1, 1, 1, 1);
        issue(16'h0F0F, 4'b0001, 1'b0, 0);
        chk("tie_done_wins", 64'(fx_timeout), 64'(4'b0010));
        // One cycle later is a timeout.
        set_lat(1, 1, 1, TO);
        issue(16'h7001, 4'b1000, 1'b1, 0);
        chk("timeout_slot3", 64'(fx_timeout), 64'(4'b1010));
        // done held high before dispatch, then drops and rises again.
        set_lat(6, 1, 1, 1);
        force_hi = 4'b0001;
        fork
            issue(16'h0100, 4'b0001, 1'b1, 0);
            begin
                repeat (3) @(negedge clk);
                chk("should_save_mid", 64'(fx_should_save), 64'(1));
                force_hi = 4'b0000;
            end
        join
        // done held high throughout: no fresh edge, so slot 0 times out.
        set_lat(3, 1, 1, 1);
        ref_lat[0] = 1000;
        force_hi   = 4'b0001;
        issue(16'h0200, 4'b0001, 1'b1, 0);
        force_hi   = 4'b0000;
        chk("timeout_held_done", 64'(fx_timeout), 64'(4'b1011));
        chk("no_overrun_before", 64'(overrun), 64'(0));
        // Second pulse while slot 0 works is dropped.
        set_lat(3, 1, 1, 1);
        issue(16'h0042, 4'b0001, 1'b0, 2);
        chk("overrun_set", 64'(overrun), 64'(1));

        // Reset in the middle of WAIT.
        set_lat(1, 10, 1, 1);
        exp_turn.push_back(1);
        sample_in    = 16'h0777;
        fx_enable    = 4'b0010;
        noise_en     = 4'b1101;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("in_wait_before_rst", 64'(fx_my_turn), 64'(4'b0010));
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({fx_cs, fx_my_turn, fx_data, fx_should_save, sample_out,
                                         sample_out_valid, busy, overrun, fx_timeout}), 64'(0));
        exp_v.delete();
        exp_c.delete();
        exp_turn.delete();
        exp_tmask = 4'b0;
        exp_ovr   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_lat(2, 3, 1, 1);
        issue(16'h0555, 4'b0011, 1'b1, 0);
        chk("overrun_cleared", 64'(overrun), 64'(0));
        // Pulse on the cycle the block returns to idle is dropped too.
        issue(16'h0033, 4'b0100, 1'b0, -2);
        chk("overrun_at_return", 64'(overrun), 64'(1));
        issue(16'h0034, 4'b0000, 1'b0, 0);

        // Randomized samples, latencies, enables and overrun pulses.
        for (int n = 0; n < 40; n++) begin
            set_lat(int'($urandom_range(18, 1)), int'($urandom_range(18, 1)),
                    int'($urandom_range(18, 1)), int'($urandom_range(18, 1)));
            issue(16'($urandom), 4'($urandom), 1'($urandom),
                  ($urandom_range(4, 0) == 0) ? -1 : 0);
        end
        chk("final_timeouts", 64'(fx_timeout), 64'(exp_tmask));
        chk("final_overrun", 64'(overrun), 64'(exp_ovr));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/effect_sequencer.md
EFFECT_SEQUENCER -- requirements
Module: effect_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width in bits.
REQ-002 Parameter NUM_FX, default 4, number of effect slots; slot 0 is processed first.
REQ-003 Parameter TIMEOUT, default 4096, maximum cycles allowed per slot before the slot is bypassed.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sample_in  input  DATA_WIDTH  codec sample, valid while sample_valid is high.
REQ-007 sample_valid  input  1  one-cycle pulse per new codec sample.
REQ-008 fx_enable  input  NUM_FX  per-slot enable; bit i enables slot i.
REQ-009 save_enable  input  1  requested should_save level for effects.
REQ-010 fx_done  input  NUM_FX  per-slot done from each effect.
REQ-011 fx_result  input  NUM_FX*DATA_WIDTH  effect data_out buses; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 fx_cs  output  NUM_FX  per-slot chip select.
REQ-013 fx_my_turn  output  NUM_FX  per-slot start/hold strobe; at most one bit high.
REQ-014 fx_data  output  DATA_WIDTH  shared data_in bus to all effects.
REQ-015 fx_should_save  output  1  shared should_save to all effects.
REQ-016 sample_out  output  DATA_WIDTH  processed sample to codec DAC path.
REQ-017 sample_out_valid  output  1  one-cycle pulse marking a new sample_out.
REQ-018 busy  output  1  high in every state other than IDLE.
REQ-019 overrun  output  1  sticky flag: sample dropped.
REQ-020 fx_timeout  output  NUM_FX  sticky per-slot timeout flags.

Function
REQ-021 FSM states SHALL be IDLE, SELECT, WAIT, with index register idx (width clog2(NUM_FX+1)) and sample register cur.
REQ-022 In IDLE with sample_valid=1: latch cur<=sample_in, idx<=0, snapshot fx_enable into en_q and save_enable into fx_should_save, go to SELECT.
REQ-023 fx_cs SHALL equal en_q; fx_enable and save_enable changes mid-sample take effect at the next sample only.
REQ-024 In SELECT with idx==NUM_FX: sample_out<=cur, sample_out_valid pulses for one cycle, go to IDLE.
REQ-025 In SELECT with en_q[idx]=0: idx<=idx+1, stay in SELECT; a disabled slot costs exactly one cycle and leaves cur unchanged.
REQ-026 In SELECT with en_q[idx]=1: fx_my_turn[idx]<=1, clear timeout counter, go to WAIT.
REQ-027 fx_data SHALL equal cur at all times.
REQ-028 In WAIT, rising edge of fx_done[idx] (high now, low previous cycle; one register stage per bit): cur<=fx_result slice idx, fx_my_turn<=0, idx<=idx+1, go to SELECT.
REQ-029 A fx_done[idx] already high when WAIT is entered SHALL NOT count; a fresh rising edge is required.
REQ-030 In WAIT, if counter reaches TIMEOUT-1 with no done edge: set fx_timeout[idx], fx_my_turn<=0, cur unchanged (bypass), idx<=idx+1, go to SELECT.
REQ-031 A done edge and timeout in the same cycle: done wins, no flag set.
REQ-032 sample_valid while not in IDLE: sample discarded, overrun<=1, processing of the current sample continues unaffected.
REQ-033 sample_valid in the same cycle as the transition to IDLE is discarded and sets overrun.
REQ-034 Latency, all slots disabled: sample_out_valid high NUM_FX+1 cycles after the edge that samples sample_valid.
REQ-035 Sticky flags clear only on reset.
REQ-036 fx_done bits of slots other than idx are ignored.

Reset
REQ-037 While rst=1, asynchronously: state=IDLE; idx, cur, en_q=0; fx_cs, fx_my_turn, fx_data, fx_should_save, sample_out, sample_out_valid, busy, overrun, fx_timeout=0.
REQ-038 Reset asserted mid-WAIT SHALL drop fx_my_turn immediately; the in-flight sample is lost and no sample_out_valid is produced.

Verification
REQ-039 fx_enable=0000, sample_in=0x1234 pulse -> sample_out=0x1234, sample_out_valid exactly 5 cycles after the pulse, fx_my_turn stays 0.
REQ-040 fx_enable=0101, slot 0 model returns input+1 after 3 cycles, slot 2 returns input*2; sample_in=10 -> fx_my_turn 0001 then 0100, sample_out=22.
REQ-041 fx_enable=0010, slot 1 never asserts done, TIMEOUT=16 -> fx_timeout=0010 after 16 WAIT cycles, sample_out equals sample_in=0x00AA.
REQ-042 Second sample_valid issued 2 cycles after the first while slot 0 busy -> overrun=1, exactly one sample_out_valid, value derived from the first sample.
REQ-043 fx_done[0] held high before dispatch, save_enable=1 -> no capture until done drops and rises again; fx_should_save=1 throughout.
REQ-044 rst pulsed during WAIT -> all outputs 0 in the same cycle, next sample processed normally.
